// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic-unit constants and state types
package arith_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 5;
  localparam int PROD_W    = 2 * WIDTH_DEF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mul_step.sv
// rtl/mul_step.sv - one shift-and-add iteration of the unsigned multiplier
module mul_step #(
  parameter int WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplr,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0]   mplr_next
);

  assign acc_next   = mplr[0] ? (acc + mcand) : acc;
  assign mcand_next = mcand << 1;
  assign mplr_next  = mplr >> 1;

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - iterative WIDTHxWIDTH unsigned multiplier, one multiplier bit per cycle
module mul_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     out,
  output logic                 ov,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t            state, state_n;
  logic [PW-1:0]     acc, acc_n, mcand, mcand_n, prod_n;
  logic [WIDTH-1:0]  mplr, mplr_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              done_n;
  logic [PW-1:0]     step_acc, step_mcand;
  logic [WIDTH-1:0]  step_mplr;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplr       (mplr),
    .acc_next   (step_acc),
    .mcand_next (step_mcand),
    .mplr_next  (step_mplr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplr    <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      mcand   <= mcand_n;
      mplr    <= mplr_n;
      cnt     <= cnt_n;
      done    <= done_n;
      product <= prod_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    mcand_n = mcand;
    mplr_n  = mplr;
    cnt_n   = cnt;
    done_n  = 1'b0;
    prod_n  = product;
    case (state)
      IDLE: begin
        if (start) begin
          acc_n   = '0;
          mcand_n = {{WIDTH{1'b0}}, a};
          mplr_n  = b;
          cnt_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        acc_n   = step_acc;
        mcand_n = step_mcand;
        mplr_n  = step_mplr;
        cnt_n   = cnt + CNT_W'(1);
        // Fixed iteration count: zero operands still take the full WIDTH cycles.
        if (cnt == LAST) begin
          prod_n  = step_acc;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign out  = product[WIDTH-1:0];
  assign ov   = |product[PW-1:WIDTH];

endmodule
